// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers.
//   SAT_CNT_W  : width of saturation event counters
//   nch_w()    : index width for a table of n entries (at least 1 bit)
//   sat_signed : clamp a wide signed value to the range of a narrower signed width
package fxp_pkg;

  localparam int SAT_CNT_W = 16;

  function automatic int nch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp to [-2^(width-1), 2^(width-1)-1]. The result is still 64 bits wide;
  // the caller slices the low 'width' bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/fxp_mul_shift_sat.sv
// Combinational multiply, arithmetic left shift, saturate.
//   d_i    : signed operand (DW bits)
//   mult_i : signed multiplier (MW bits)
//   y_o    : saturated result (NOUT bits)
//   sat_o  : high when the shifted product fell outside the NOUT range
// The product is shifted at full width, so no bits are lost before saturation.
// DW + MW + SHIFT must not exceed 63.
module fxp_mul_shift_sat
  import fxp_pkg::*;
#(
  parameter int DW    = 9,
  parameter int MW    = 16,
  parameter int SHIFT = 7,
  parameter int NOUT  = 32
) (
  input  logic signed [DW-1:0]   d_i,
  input  logic signed [MW-1:0]   mult_i,
  output logic signed [NOUT-1:0] y_o,
  output logic                   sat_o
);

  localparam int PW = DW + MW;

  logic signed [PW-1:0] prod;
  logic signed [63:0]   wide;
  logic signed [63:0]   clamped;

  assign prod    = d_i * mult_i;
  assign wide    = $signed({{(64 - PW){prod[PW-1]}}, prod}) <<< SHIFT;
  assign clamped = sat_signed(wide, NOUT);
  assign y_o     = clamped[NOUT-1:0];
  assign sat_o   = (clamped != wide);

endmodule

// File: rtl/fxp_dequant_stream.sv
// Streaming dequantizer: out = sat((in_data - zp) * mult[ch] <<< SHIFT).
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input stream handshake; in_data, zp, in_last qualify a beat
//   cfg_we/addr/mult    : per-channel multiplier table write port (never stalls)
//   out_valid/out_ready : output stream handshake; out_data, out_ch, out_last, out_sat
//   sat_cnt / sat_clr   : count of delivered saturated beats (sticky at max) / clear
//
// Handshake: a beat transfers on a cycle where valid && ready at the rising edge.
// The producer holds its payload stable while valid && !ready. in_ready depends
// only on registered state and out_ready: adv2 = !out_valid || out_ready,
// adv1 = !s1_valid || adv2, in_ready = adv1.
//
// Two register stages: S1 holds (in_data - zp) at NIN+1 bits plus the channel's
// multiplier; S2 is the output register, loaded from the multiply/shift/saturate.
module fxp_dequant_stream
  import fxp_pkg::*;
#(
  parameter int NIN    = 8,
  parameter int NOUT   = 32,
  parameter int MULT_W = 16,
  parameter int SHIFT  = 7,
  parameter int NCH    = 4,
  localparam int CH_W  = nch_w(NCH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [NIN-1:0]  in_data,
  input  logic                   in_last,
  input  logic signed [NIN-1:0]  zp,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_addr,
  input  logic signed [MULT_W-1:0] cfg_mult,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [NOUT-1:0] out_data,
  output logic [CH_W-1:0]        out_ch,
  output logic                   out_last,
  output logic                   out_sat,
  output logic [SAT_CNT_W-1:0]   sat_cnt,
  input  logic                   sat_clr
);

  logic signed [MULT_W-1:0] mult_q [NCH];
  logic [CH_W-1:0]          ch_q;

  logic                     s1_valid_q;
  logic signed [NIN:0]      s1_d_q;
  logic signed [MULT_W-1:0] s1_mult_q;
  logic [CH_W-1:0]          s1_ch_q;
  logic                     s1_last_q;

  logic                     adv1, adv2, accept;
  logic signed [NIN:0]      d_in;
  logic signed [NOUT-1:0]   y;
  logic                     y_sat;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;
  assign accept   = in_valid && adv1;

  assign d_in = $signed({in_data[NIN-1], in_data}) - $signed({zp[NIN-1], zp});

  // Multiplier table. A beat entering S1 on the same edge as a write reads the
  // previous entry because both are sampled before the edge updates mult_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) mult_q[i] <= MULT_W'(1);
    end else if (cfg_we) begin
      mult_q[cfg_addr] <= cfg_mult;
    end
  end

  // Channel counter: in_last forces the next beat back to channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q <= '0;
    end else if (accept) begin
      if (in_last || ch_q == CH_W'(NCH - 1)) ch_q <= '0;
      else                                    ch_q <= ch_q + 1'b1;
    end
  end

  // Stage 1
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_d_q     <= '0;
      s1_mult_q  <= '0;
      s1_ch_q    <= '0;
      s1_last_q  <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_d_q    <= d_in;
        s1_mult_q <= mult_q[ch_q];
        s1_ch_q   <= ch_q;
        s1_last_q <= in_last;
      end
    end
  end

  fxp_mul_shift_sat #(
    .DW   (NIN + 1),
    .MW   (MULT_W),
    .SHIFT(SHIFT),
    .NOUT (NOUT)
  ) u_mss (
    .d_i   (s1_d_q),
    .mult_i(s1_mult_q),
    .y_o   (y),
    .sat_o (y_sat)
  );

  // Stage 2 / output register. Payload only changes when adv2, so it is held
  // while out_valid && !out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        out_data <= y;
        out_ch   <= s1_ch_q;
        out_last <= s1_last_q;
        out_sat  <= y_sat;
      end
    end
  end

  // Saturation counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && out_sat && sat_cnt != '1) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule
